idex_stage_reg: RTL and testbench

ID/EX pipeline register of the 5-stage core. It is the receiving end of the load-use stall protocol. It consumes the pause signals issued by the hazard unit and the branch flush from EX. Depending on those inputs it captures the decoded instruction, injects a bubble, or freezes. It also drives the EX-stage fields (`wen`, `wb_sel`, `waddr`) back to the hazard unit and keeps bubble/flush performance counters plus a protocol-violation flag.

---
 rtl/idex_stage_reg_pkg.sv | 43 ++++
 rtl/idex_stage_reg_if.sv | 69 ++++++
 rtl/idex_stage_reg_perf_counter.sv | 22 ++
 rtl/idex_stage_reg.sv | 80 ++++++++
 tb/tb_idex_stage_reg.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/idex_stage_reg_pkg.sv
// Shared types and constants for the ID/EX stage register.
// Write-back selects, bubble instruction, register widths, action decode.
package idex_stage_reg_pkg;

   localparam int REG_W      = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [REG_W-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      WB_FROM_ALU = 2'b00,
      WB_FROM_DM  = 2'b01,
      WB_FROM_PC  = 2'b10
   } wb_sel_e;

   typedef enum logic [1:0] {
      ACT_LOAD,
      ACT_PAUSE,
      ACT_FLUSH,
      ACT_HOLD
   } act_e;

   // hold beats flush beats pause; terms are made disjoint
   function automatic act_e stage_act(
      input logic hold,
      input logic flush,
      input logic pause
   );
      act_e a;
      a = ACT_LOAD;
      unique case (1'b1)
         hold:                    a = ACT_HOLD;
         !hold && flush:          a = ACT_FLUSH;
         !hold && !flush && pause: a = ACT_PAUSE;
         default:                 a = ACT_LOAD;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/idex_stage_reg_if.sv
// ID/EX bundle: hazard controls and ID fields in, EX fields and stats out.
// master = ID side / hazard unit, slave = the stage register.
interface idex_stage_reg_if
   import idex_stage_reg_pkg::*;
#(
   parameter int ALU_OP_W = 4
) ();

   logic                  pause_i;
   logic                  hold_i;
   logic                  flush_i;

   logic                  id_valid_i;
   logic [REG_W-1:0]      id_pc_i;
   logic [REG_W-1:0]      id_inst_i;
   logic [REG_W-1:0]      id_op1_i;
   logic [REG_W-1:0]      id_op2_i;
   logic [REG_W-1:0]      id_imm_i;
   logic [ALU_OP_W-1:0]   id_alu_op_i;
   logic                  id_wen_i;
   logic [1:0]            id_wb_sel_i;
   logic [REG_ADDR_W-1:0] id_reg_waddr_i;
   logic                  id_mem_wen_i;
   logic                  id_mem_ren_i;

   logic                  ex_valid_o;
   logic [REG_W-1:0]      ex_pc_o;
   logic [REG_W-1:0]      ex_inst_o;
   logic [REG_W-1:0]      ex_op1_o;
   logic [REG_W-1:0]      ex_op2_o;
   logic [REG_W-1:0]      ex_imm_o;
   logic [ALU_OP_W-1:0]   ex_alu_op_o;
   logic                  ex_wen_o;
   logic [1:0]            ex_wb_sel_o;
   logic [REG_ADDR_W-1:0] ex_reg_waddr_o;
   logic                  ex_mem_wen_o;
   logic                  ex_mem_ren_o;

   logic [31:0]           bubble_cnt_o;
   logic [31:0]           flush_cnt_o;
   logic                  pause_err_o;

   modport master (
      output pause_i, hold_i, flush_i,
      output id_valid_i, id_pc_i, id_inst_i,
      output id_op1_i, id_op2_i, id_imm_i,
      output id_alu_op_i, id_wen_i, id_wb_sel_i,
      output id_reg_waddr_i, id_mem_wen_i, id_mem_ren_i,
      input  ex_valid_o, ex_pc_o, ex_inst_o,
      input  ex_op1_o, ex_op2_o, ex_imm_o,
      input  ex_alu_op_o, ex_wen_o, ex_wb_sel_o,
      input  ex_reg_waddr_o, ex_mem_wen_o, ex_mem_ren_o,
      input  bubble_cnt_o, flush_cnt_o, pause_err_o
   );

   modport slave (
      input  pause_i, hold_i, flush_i,
      input  id_valid_i, id_pc_i, id_inst_i,
      input  id_op1_i, id_op2_i, id_imm_i,
      input  id_alu_op_i, id_wen_i, id_wb_sel_i,
      input  id_reg_waddr_i, id_mem_wen_i, id_mem_ren_i,
      output ex_valid_o, ex_pc_o, ex_inst_o,
      output ex_op1_o, ex_op2_o, ex_imm_o,
      output ex_alu_op_o, ex_wen_o, ex_wb_sel_o,
      output ex_reg_waddr_o, ex_mem_wen_o, ex_mem_ren_o,
      output bubble_cnt_o, flush_cnt_o, pause_err_o
   );

endinterface

// File: rtl/idex_stage_reg_perf_counter.sv
// 32-bit wrapping event counter, synchronous active-high reset.
// Ports: clk, rst, inc (count enable), count (current value).
module idex_stage_reg_perf_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);

   logic [31:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register: load, bubble (pause/flush) or freeze (hold).
// Ports: clk, rst (sync, active-high), bus (slave side of idex_stage_reg_if).
module idex_stage_reg
   import idex_stage_reg_pkg::*;
#(
   parameter int ALU_OP_W = 4
) (
   input logic              clk,
   input logic              rst,
   idex_stage_reg_if.slave  bus
);

   act_e act;
   logic load_bub;
   logic pause_seen;

   assign act      = stage_act(bus.hold_i, bus.flush_i, bus.pause_i);
   assign load_bub = (act == ACT_FLUSH) || (act == ACT_PAUSE);

   always_ff @(posedge clk) begin
      if (rst || load_bub) begin
         bus.ex_valid_o     <= FALSE;
         bus.ex_pc_o        <= '0;
         bus.ex_inst_o      <= NOP_INST;
         bus.ex_op1_o       <= '0;
         bus.ex_op2_o       <= '0;
         bus.ex_imm_o       <= '0;
         bus.ex_alu_op_o    <= {ALU_OP_W{1'b0}};
         bus.ex_wen_o       <= FALSE;
         bus.ex_wb_sel_o    <= WB_FROM_ALU;
         bus.ex_reg_waddr_o <= '0;
         bus.ex_mem_wen_o   <= FALSE;
         bus.ex_mem_ren_o   <= FALSE;
      end else if (act == ACT_LOAD) begin
         bus.ex_valid_o     <= bus.id_valid_i;
         bus.ex_pc_o        <= bus.id_pc_i;
         bus.ex_inst_o      <= bus.id_inst_i;
         bus.ex_op1_o       <= bus.id_op1_i;
         bus.ex_op2_o       <= bus.id_op2_i;
         bus.ex_imm_o       <= bus.id_imm_i;
         bus.ex_alu_op_o    <= bus.id_alu_op_i;
         bus.ex_wen_o       <= bus.id_wen_i;
         bus.ex_wb_sel_o    <= bus.id_wb_sel_i;
         bus.ex_reg_waddr_o <= bus.id_reg_waddr_i;
         bus.ex_mem_wen_o   <= bus.id_mem_wen_i;
         bus.ex_mem_ren_o   <= bus.id_mem_ren_i;
      end
   end

   // pause_seen remembers a pause in the last non-hold cycle; hold
   // cycles are transparent to it and a flush breaks the sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         pause_seen      <= FALSE;
         bus.pause_err_o <= FALSE;
      end else if (act == ACT_FLUSH) begin
         pause_seen <= FALSE;
      end else if (act != ACT_HOLD) begin
         if (bus.pause_i && pause_seen) begin
            bus.pause_err_o <= TRUE;
         end
         pause_seen <= bus.pause_i;
      end
   end

   idex_stage_reg_perf_counter u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (act == ACT_PAUSE),
      .count (bus.bubble_cnt_o)
   );

   idex_stage_reg_perf_counter u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (act == ACT_FLUSH),
      .count (bus.flush_cnt_o)
   );

endmodule

// File: tb/tb_idex_stage_reg.sv
// Directed bench for idex_stage_reg with a queue-based scoreboard.
// Driver pushes the expected EX view per cycle; monitor pops and compares.
module tb_idex_stage_reg;

   logic clk;
   logic rst;

   idex_stage_reg_if #(.ALU_OP_W(4)) bus ();

   idex_stage_reg #(.ALU_OP_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] op1;
      logic [4:0]  wa;
      logic        wen;
      logic [1:0]  wbs;
   } id_t;

   typedef struct {
      string       nm;
      id_t         d;
      logic [31:0] bc;
      logic [31:0] fc;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_pass;
   int   n_total;

   id_t id_a, id_l, id_b, id_c, id_d, id_e, id_f, id_g, id_h;

   function automatic exp_t eb(logic [31:0] bc, logic [31:0] fc, logic err);
      exp_t e;
      e.nm  = "";
      e.d   = '{1'b0, 32'h0, 32'h0000_0013, 32'h0, 5'd0, 1'b0, 2'b00};
      e.bc  = bc;
      e.fc  = fc;
      e.err = err;
      return e;
   endfunction

   function automatic exp_t el(id_t d, logic [31:0] bc, logic [31:0] fc, logic err);
      exp_t e;
      e.nm  = "";
      e.d   = d;
      e.bc  = bc;
      e.fc  = fc;
      e.err = err;
      return e;
   endfunction

   // side fields are derived from the main ones so they can be checked too
   task automatic set_id(id_t d);
      bus.id_valid_i     = d.v;
      bus.id_pc_i        = d.pc;
      bus.id_inst_i      = d.inst;
      bus.id_op1_i       = d.op1;
      bus.id_op2_i       = ~d.op1;
      bus.id_imm_i       = d.pc + 32'd4;
      bus.id_alu_op_i    = d.pc[5:2];
      bus.id_wen_i       = d.wen;
      bus.id_wb_sel_i    = d.wbs;
      bus.id_reg_waddr_i = d.wa;
      bus.id_mem_wen_i   = d.wa[0];
      bus.id_mem_ren_i   = (d.wbs == 2'b01);
   endtask

   task automatic step(string nm, logic r, logic h, logic f, logic p, exp_t e);
      exp_t x;
      rst         = r;
      bus.hold_i  = h;
      bus.flush_i = f;
      bus.pause_i = p;
      x    = e;
      x.nm = nm;
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] want);
      n_total++;
      if (act === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, want);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic bub;
         mon_e = exp_q.pop_front();
         bub   = (mon_e.d.inst == 32'h0000_0013);
         chk(mon_e.nm, "valid", 32'(bus.ex_valid_o), 32'(mon_e.d.v));
         chk(mon_e.nm, "pc", bus.ex_pc_o, mon_e.d.pc);
         chk(mon_e.nm, "inst", bus.ex_inst_o, mon_e.d.inst);
         chk(mon_e.nm, "op1", bus.ex_op1_o, mon_e.d.op1);
         chk(mon_e.nm, "waddr", 32'(bus.ex_reg_waddr_o), 32'(mon_e.d.wa));
         chk(mon_e.nm, "wen", 32'(bus.ex_wen_o), 32'(mon_e.d.wen));
         chk(mon_e.nm, "wb_sel", 32'(bus.ex_wb_sel_o), 32'(mon_e.d.wbs));
         chk(mon_e.nm, "op2", bus.ex_op2_o, bub ? 32'h0 : ~mon_e.d.op1);
         chk(mon_e.nm, "imm", bus.ex_imm_o, bub ? 32'h0 : mon_e.d.pc + 32'd4);
         chk(mon_e.nm, "alu_op", 32'(bus.ex_alu_op_o),
             bub ? 32'h0 : 32'(mon_e.d.pc[5:2]));
         chk(mon_e.nm, "mem_wen", 32'(bus.ex_mem_wen_o),
             bub ? 32'h0 : 32'(mon_e.d.wa[0]));
         chk(mon_e.nm, "mem_ren", 32'(bus.ex_mem_ren_o),
             bub ? 32'h0 : 32'(mon_e.d.wbs == 2'b01));
         chk(mon_e.nm, "bubble_cnt", bus.bubble_cnt_o, mon_e.bc);
         chk(mon_e.nm, "flush_cnt", bus.flush_cnt_o, mon_e.fc);
         chk(mon_e.nm, "pause_err", 32'(bus.pause_err_o), 32'(mon_e.err));
      end
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      id_a = '{1'b1, 32'h100, 32'h0050_0293, 32'h0,   5'd5,  1'b1, 2'b00};
      id_l = '{1'b1, 32'h104, 32'h0002_a303, 32'h10,  5'd6,  1'b1, 2'b01};
      id_b = '{1'b1, 32'h108, 32'h0063_03b3, 32'h20,  5'd7,  1'b1, 2'b00};
      id_c = '{1'b1, 32'h10c, 32'h0000_0463, 32'h30,  5'd0,  1'b0, 2'b00};
      id_d = '{1'b1, 32'h200, 32'h00a0_0513, 32'habc, 5'd10, 1'b1, 2'b00};
      id_e = '{1'b1, 32'h204, 32'h0000_05ef, 32'h555, 5'd11, 1'b1, 2'b10};
      id_f = '{1'b0, 32'h208, 32'h00c0_0613, 32'h1,   5'd12, 1'b0, 2'b00};
      id_g = '{1'b1, 32'h20c, 32'h00d0_0693, 32'h2,   5'd13, 1'b1, 2'b00};
      id_h = '{1'b1, 32'h300, 32'h00e0_0713, 32'h3,   5'd14, 1'b1, 2'b00};

      rst         = 1'b1;
      bus.hold_i  = 1'b0;
      bus.flush_i = 1'b0;
      bus.pause_i = 1'b0;
      set_id(id_a);
      @(negedge clk);

      step("rst0", 1, 0, 0, 0, eb(0, 0, 0));
      step("rst_pause", 1, 0, 0, 1, eb(0, 0, 0));
      step("load_a", 0, 0, 0, 0, el(id_a, 0, 0, 0));
      set_id(id_l);
      step("load_l", 0, 0, 0, 0, el(id_l, 0, 0, 0));
      set_id(id_b);
      step("pause1", 0, 0, 0, 1, eb(1, 0, 0));
      step("load_b", 0, 0, 0, 0, el(id_b, 1, 0, 0));
      set_id(id_c);
      step("flush_pause", 0, 0, 1, 1, eb(1, 1, 0));
      set_id(id_d);
      step("load_d", 0, 0, 0, 0, el(id_d, 1, 1, 0));
      set_id(id_e);
      step("hold0", 0, 1, 0, 1, el(id_d, 1, 1, 0));
      step("hold1", 0, 1, 1, 1, el(id_d, 1, 1, 0));
      step("hold2", 0, 1, 0, 1, el(id_d, 1, 1, 0));
      step("pause_after_hold", 0, 0, 0, 1, eb(2, 1, 0));
      step("load_e", 0, 0, 0, 0, el(id_e, 2, 1, 0));
      set_id(id_f);
      step("pause_a", 0, 0, 0, 1, eb(3, 1, 0));
      step("hold_bubble", 0, 1, 0, 1, eb(3, 1, 0));
      step("load_f", 0, 0, 0, 0, el(id_f, 3, 1, 0));
      step("pause_b", 0, 0, 0, 1, eb(4, 1, 0));
      step("flush_only", 0, 0, 1, 0, eb(4, 2, 0));
      step("pause_c", 0, 0, 0, 1, eb(5, 2, 0));
      set_id(id_g);
      step("load_g", 0, 0, 0, 0, el(id_g, 5, 2, 0));
      step("pause_d", 0, 0, 0, 1, eb(6, 2, 0));
      step("pause_e", 0, 0, 0, 1, eb(7, 2, 1));
      set_id(id_h);
      for (int i = 0; i < 10; i++) begin
         step("idle_sticky", 0, 0, 0, 0, el(id_h, 7, 2, 1));
      end
      step("rst_a", 1, 0, 0, 1, eb(0, 0, 0));
      step("pause_post_rst", 0, 0, 0, 1, eb(1, 0, 0));
      step("load_h", 0, 0, 0, 0, el(id_h, 1, 0, 0));
      step("pause_f", 0, 0, 0, 1, eb(2, 0, 0));
      step("hold_mid", 0, 1, 0, 1, eb(2, 0, 0));
      step("pause_g", 0, 0, 0, 1, eb(3, 0, 1));
      step("rst_b", 1, 1, 1, 1, eb(0, 0, 0));

      force dut.u_bubble_cnt.cnt_q = 32'hffff_ffff;
      step("preload", 0, 0, 0, 0, el(id_h, 32'hffff_ffff, 0, 0));
      release dut.u_bubble_cnt.cnt_q;
      step("wrap", 0, 0, 0, 1, eb(0, 0, 0));
      step("after_wrap", 0, 0, 0, 0, el(id_h, 0, 0, 0));

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      #2;
      n_total++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
